// File: rtl/ddr_sched_pkg.sv
// Shared types and constants for the DDR3 MIG command scheduler.
//   sched_state_t : arbiter FSM states
//   CMD_WRITE     : MIG UI app_cmd encoding for a write
//   CMD_READ      : MIG UI app_cmd encoding for a read
package ddr_sched_pkg;

    typedef enum logic [2:0] {
        WAIT_INIT,
        IDLE,
        RD,
        WR,
        TURN
    } sched_state_t;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/ddr_cmd_scheduler_if.sv
// Handshake bundle between the command scheduler, the MIG UI command/write-data
// ports and the two request streams (camera writes, HDMI read requests).
//   master : the scheduler side (drives strobes and readies)
//   slave  : the environment side (MIG + request sources)
interface ddr_cmd_scheduler_if;

    // MIG UI
    logic       app_rdy;
    logic       app_wdf_rdy;
    logic       app_rd_data_valid;
    logic       app_en;
    logic [2:0] app_cmd;
    logic       app_wdf_wren;
    logic       app_wdf_end;

    // Request streams
    logic       wr_req_valid;
    logic       wr_req_ready;
    logic       rd_req_valid;
    logic       rd_req_ready;
    logic       rd_fifo_af;

    modport master (
        input  app_rdy, app_wdf_rdy, app_rd_data_valid,
        input  wr_req_valid, rd_req_valid, rd_fifo_af,
        output app_en, app_cmd, app_wdf_wren, app_wdf_end,
        output wr_req_ready, rd_req_ready
    );

    modport slave (
        output app_rdy, app_wdf_rdy, app_rd_data_valid,
        output wr_req_valid, rd_req_valid, rd_fifo_af,
        input  app_en, app_cmd, app_wdf_wren, app_wdf_end,
        input  wr_req_ready, rd_req_ready
    );

endinterface

// File: rtl/credit_counter.sv
// Up/down credit counter that saturates at zero and latches a sticky
// underflow flag when a decrement arrives with nothing to take away.
//   clk_in, rst_in : clock, asynchronous active-low reset
//   inc, dec       : count up / count down this cycle (both = no change)
//   count          : current credit count
//   underflow      : sticky, set by dec while count == 0
module credit_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         underflow
);

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (dec && (count == '0))
                underflow <= 1'b1;

            if (inc && !dec)
                count <= count + W'(1);
            else if (dec && !inc && (count != '0))
                count <= count - W'(1);
        end
    end

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// Arbitrates the MIG UI command port between the camera write stream and the
// HDMI read-request generator. Bounded bursts while contested, a fixed idle
// gap on every direction change, a cap on reads in flight and read-FIFO
// back-pressure. Only handshakes, strobes and select/status are driven here.
//   clk_in, rst_in       : MIG ui_clk, asynchronous active-low reset
//   init_calib_complete  : MIG calibration done; low forces WAIT_INIT
//   bus                  : MIG UI + request-stream handshakes (master side)
//   sel_rd               : address mux select, 1 = read address
//   outstanding          : reads issued but not yet returned
//   err_underflow        : sticky, read data returned with none outstanding
module ddr_cmd_scheduler
    import ddr_sched_pkg::*;
#(
    parameter int unsigned RD_BURST        = 8,
    parameter int unsigned WR_BURST        = 8,
    parameter int unsigned TURNAROUND      = 2,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 init_calib_complete,
    ddr_cmd_scheduler_if.master  bus,
    output logic                 sel_rd,
    output logic [OUT_W-1:0]     outstanding,
    output logic                 err_underflow
);

    localparam int unsigned BURST_MAX = (RD_BURST > WR_BURST) ? RD_BURST : WR_BURST;
    localparam int unsigned BURST_W   = $clog2(BURST_MAX + 1);
    localparam int unsigned TURN_LAST_I = TURNAROUND - 1;

    localparam logic [BURST_W:0]   RD_LIMIT  = RD_BURST[BURST_W:0];
    localparam logic [BURST_W:0]   WR_LIMIT  = WR_BURST[BURST_W:0];
    localparam logic [BURST_W-1:0] BURST_SAT = BURST_MAX[BURST_W-1:0];
    localparam logic [OUT_W-1:0]   MAX_OUT   = MAX_OUTSTANDING[OUT_W-1:0];
    localparam logic [3:0]         TURN_LAST = TURN_LAST_I[3:0];

    sched_state_t       state, state_nxt;
    logic [BURST_W-1:0] burst;
    logic [BURST_W:0]   burst_now;
    logic [3:0]         turn_cnt;
    logic               turn_to_rd, turn_to_rd_nxt;
    logic               rd_credit;
    logic               rd_ok;
    logic               rd_hs, wr_hs;

    assign rd_credit = !bus.rd_fifo_af && (outstanding < MAX_OUT);
    assign rd_ok     = bus.rd_req_valid && rd_credit;

    // Burst length including this cycle's handshake, so the grant ends on the
    // edge right after the last allowed beat completes.
    assign burst_now = {1'b0, burst} + {{BURST_W{1'b0}}, (rd_hs | wr_hs)};

    // ---------------- state register ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state <= WAIT_INIT;
        else
            state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        turn_to_rd_nxt = turn_to_rd;

        if (!init_calib_complete) begin
            state_nxt = WAIT_INIT;
        end else begin
            case (state)
                WAIT_INIT: state_nxt = IDLE;

                IDLE: begin
                    // Reads win ties: the display has a hard deadline.
                    if (rd_ok)
                        state_nxt = RD;
                    else if (bus.wr_req_valid)
                        state_nxt = WR;
                end

                RD: begin
                    if (bus.wr_req_valid && ((burst_now >= RD_LIMIT) || !rd_ok)) begin
                        state_nxt      = TURN;
                        turn_to_rd_nxt = 1'b0;
                    end else if (!bus.wr_req_valid && !rd_ok) begin
                        state_nxt = IDLE;
                    end
                end

                WR: begin
                    if (rd_ok && ((burst_now >= WR_LIMIT) || !bus.wr_req_valid)) begin
                        state_nxt      = TURN;
                        turn_to_rd_nxt = 1'b1;
                    end else if (!bus.wr_req_valid && !rd_ok) begin
                        state_nxt = IDLE;
                    end
                end

                TURN: begin
                    if (turn_cnt == TURN_LAST)
                        state_nxt = turn_to_rd ? RD : WR;
                end

                default: state_nxt = WAIT_INIT;
            endcase
        end
    end

    // ---------------- outputs (zero-latency handshakes) ----------------
    always_comb begin
        rd_hs            = 1'b0;
        wr_hs            = 1'b0;
        bus.rd_req_ready = 1'b0;
        bus.wr_req_ready = 1'b0;
        bus.app_cmd      = CMD_WRITE;
        sel_rd           = 1'b0;

        case (state)
            RD: begin
                bus.rd_req_ready = rd_credit && bus.app_rdy;
                rd_hs            = rd_ok && bus.app_rdy;
                bus.app_cmd      = CMD_READ;
                sel_rd           = 1'b1;
            end
            WR: begin
                bus.wr_req_ready = bus.app_rdy && bus.app_wdf_rdy;
                wr_hs            = bus.wr_req_valid && bus.app_rdy && bus.app_wdf_rdy;
            end
            TURN: sel_rd = turn_to_rd;
            default: ;
        endcase

        bus.app_en       = rd_hs | wr_hs;
        bus.app_wdf_wren = wr_hs;
        bus.app_wdf_end  = wr_hs;
    end

    // ---------------- burst / turnaround bookkeeping ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            burst      <= '0;
            turn_cnt   <= '0;
            turn_to_rd <= 1'b0;
        end else begin
            turn_to_rd <= turn_to_rd_nxt;

            // Any state change restarts the burst, which covers every entry
            // to RD or WR. The count saturates so an uncontested stream can
            // run forever without wrapping.
            if (state_nxt != state)
                burst <= '0;
            else if ((rd_hs || wr_hs) && (burst != BURST_SAT))
                burst <= burst + 1'b1;

            if ((state == TURN) && (state_nxt == TURN))
                turn_cnt <= turn_cnt + 4'd1;
            else
                turn_cnt <= '0;
        end
    end

    // Returns keep counting in every state, including WAIT_INIT.
    credit_counter #(
        .W (OUT_W)
    ) u_rd_credits (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inc       (rd_hs),
        .dec       (bus.app_rd_data_valid),
        .count     (outstanding),
        .underflow (err_underflow)
    );

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler. Each scenario pushes its hand-derived
// command sequence into a queue; an independent monitor pops one entry for
// every app_en it sees and compares the strobes and select.
module tb_ddr_cmd_scheduler;

    localparam int OUT_W = 4;

    // {app_cmd, app_wdf_wren, app_wdf_end, sel_rd}
    localparam logic [5:0] EXP_RD = 6'b001_0_0_1;
    localparam logic [5:0] EXP_WR = 6'b000_1_1_0;

    logic             clk_in;
    logic             rst_in;
    logic             init_calib_complete;
    logic             sel_rd;
    logic [OUT_W-1:0] outstanding;
    logic             err_underflow;

    ddr_cmd_scheduler_if bus ();

    ddr_cmd_scheduler dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .init_calib_complete (init_calib_complete),
        .bus                 (bus),
        .sel_rd              (sel_rd),
        .outstanding         (outstanding),
        .err_underflow       (err_underflow)
    );

    int         errors;
    int         checks;
    int         cyc;
    logic [5:0] exp_q[$];

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    task automatic push_rd(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(EXP_RD);
    endtask

    task automatic push_wr(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(EXP_WR);
    endtask

    // Advance to the given cycle; returns 1 time unit after that cycle's edge.
    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
            cyc++;
        end
    endtask

    task automatic check_sb(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Reset with both request streams asserted to show nothing leaks out,
    // then release; returns at cycle 0 with requests cleared and calib low.
    task automatic reset_dut();
        rst_in                  = 1'b0;
        init_calib_complete     = 1'b0;
        bus.app_rdy             = 1'b1;
        bus.app_wdf_rdy         = 1'b1;
        bus.app_rd_data_valid   = 1'b0;
        bus.wr_req_valid        = 1'b1;
        bus.rd_req_valid        = 1'b1;
        bus.rd_fifo_af          = 1'b0;
        @(negedge clk_in);
        check("reset_strobes", 32'({bus.app_en, bus.app_cmd, bus.app_wdf_wren, bus.app_wdf_end,
                                    sel_rd, bus.rd_req_ready, bus.wr_req_ready}), 32'd0);
        check("reset_outstanding", 32'(outstanding), 32'd0);
        check("reset_err_underflow", 32'(err_underflow), 32'd0);
        @(posedge clk_in);
        #1;
        bus.wr_req_valid = 1'b0;
        bus.rd_req_valid = 1'b0;
        rst_in           = 1'b1;
        cyc              = 0;
    endtask

    // Scoreboard monitor: one queue entry per issued command.
    always @(negedge clk_in) begin
        if (rst_in && bus.app_en) begin
            if (exp_q.size() == 0)
                check("unexpected_cmd", 32'(bus.app_en), 32'd0);
            else
                check("cmd", 32'({bus.app_cmd, bus.app_wdf_wren, bus.app_wdf_end, sel_rd}),
                      32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;

        // ---- Calibration gating and first-read latency ----
        reset_dut();
        bus.rd_req_valid = 1'b1;
        go_to(9);
        @(negedge clk_in);
        check("no_cmd_before_calib", 32'(bus.app_en), 32'd0);
        go_to(10);
        init_calib_complete = 1'b1;
        push_rd(1);
        go_to(11);
        @(negedge clk_in);
        check("calib_plus1_no_cmd", 32'(bus.app_en), 32'd0);
        go_to(12);
        @(negedge clk_in);
        check("first_read_calib_plus2", 32'({bus.app_en, bus.rd_req_ready, sel_rd}), 32'd7);
        go_to(13);
        bus.rd_req_valid = 1'b0;
        @(negedge clk_in);
        check("outstanding_one_read", 32'(outstanding), 32'd1);
        go_to(14);
        bus.app_rd_data_valid = 1'b1;
        go_to(15);
        bus.app_rd_data_valid = 1'b0;
        @(negedge clk_in);
        check("outstanding_returned", 32'(outstanding), 32'd0);
        check("no_underflow_normal", 32'(err_underflow), 32'd0);
        go_to(16);
        check_sb("sb_calib");

        // ---- Contention: 8 reads, 2-cycle gap, writes, credit stall ----
        reset_dut();
        init_calib_complete = 1'b1;
        bus.rd_req_valid    = 1'b1;
        bus.wr_req_valid    = 1'b1;
        push_rd(8);
        push_wr(8);
        push_rd(1);
        go_to(9);
        @(negedge clk_in);
        check("eighth_read", 32'({bus.app_en, sel_rd}), 32'd3);
        go_to(10);
        @(negedge clk_in);
        check("turn_gap1", 32'({bus.app_en, sel_rd}), 32'd0);
        go_to(11);
        @(negedge clk_in);
        check("turn_gap2", 32'({bus.app_en, sel_rd}), 32'd0);
        go_to(12);
        @(negedge clk_in);
        check("first_write", 32'({bus.app_en, bus.app_wdf_wren}), 32'd3);
        go_to(20);
        bus.wr_req_valid = 1'b0;
        @(negedge clk_in);
        check("credit_stall_no_read", 32'({bus.app_en, bus.rd_req_ready}), 32'd0);
        check("outstanding_full", 32'(outstanding), 32'd8);
        go_to(24);
        bus.app_rd_data_valid = 1'b1;
        go_to(25);
        bus.app_rd_data_valid = 1'b0;
        @(negedge clk_in);
        check("credit_freed", 32'(outstanding), 32'd7);
        go_to(26);
        @(negedge clk_in);
        check("read_after_credit", 32'({bus.app_en, sel_rd}), 32'd3);
        go_to(28);
        bus.rd_req_valid = 1'b0;
        @(negedge clk_in);
        check("outstanding_refilled", 32'(outstanding), 32'd8);
        go_to(29);
        check_sb("sb_contention");

        // ---- Uncontested reads with a return every cycle ----
        reset_dut();
        init_calib_complete = 1'b1;
        bus.rd_req_valid    = 1'b1;
        push_rd(10);
        go_to(3);
        bus.app_rd_data_valid = 1'b1;
        go_to(5);
        @(negedge clk_in);
        check("steady_outstanding_a", 32'(outstanding), 32'd1);
        go_to(11);
        @(negedge clk_in);
        check("steady_outstanding_b", 32'(outstanding), 32'd1);
        check("still_reading", 32'({sel_rd, bus.wr_req_ready, bus.app_en}), 32'd5);
        go_to(12);
        bus.rd_req_valid = 1'b0;
        go_to(13);
        bus.app_rd_data_valid = 1'b0;
        @(negedge clk_in);
        check("steady_drained", 32'(outstanding), 32'd0);
        check("steady_no_underflow", 32'(err_underflow), 32'd0);
        go_to(14);
        check_sb("sb_uncontested");

        // ---- Read FIFO almost-full forces a switch to writes ----
        reset_dut();
        init_calib_complete = 1'b1;
        bus.rd_req_valid    = 1'b1;
        bus.wr_req_valid    = 1'b1;
        push_rd(2);
        push_wr(3);
        push_rd(1);
        go_to(4);
        bus.rd_fifo_af = 1'b1;
        @(negedge clk_in);
        check("af_drops_ready", 32'({bus.rd_req_ready, bus.app_en}), 32'd0);
        go_to(5);
        @(negedge clk_in);
        check("af_turn_to_wr", 32'({bus.app_en, sel_rd}), 32'd0);
        go_to(7);
        @(negedge clk_in);
        check("af_write", 32'({bus.wr_req_ready, bus.app_en, bus.app_wdf_wren}), 32'd7);
        go_to(10);
        bus.wr_req_valid = 1'b0;
        bus.rd_fifo_af   = 1'b0;
        @(negedge clk_in);
        check("wr_idle_beat", 32'(bus.app_en), 32'd0);
        go_to(11);
        @(negedge clk_in);
        check("turn_to_rd_sel", 32'({sel_rd, bus.app_en}), 32'd2);
        go_to(13);
        @(negedge clk_in);
        check("read_after_turn", 32'({bus.app_en, sel_rd, bus.rd_req_ready}), 32'd7);
        go_to(14);
        bus.rd_req_valid = 1'b0;
        @(negedge clk_in);
        check("af_outstanding", 32'(outstanding), 32'd3);
        go_to(15);
        check_sb("sb_fifo_af");

        // ---- Underflow: return with nothing outstanding ----
        reset_dut();
        init_calib_complete = 1'b1;
        go_to(3);
        bus.app_rd_data_valid = 1'b1;
        @(negedge clk_in);
        check("underflow_not_yet", 32'(err_underflow), 32'd0);
        go_to(4);
        bus.app_rd_data_valid = 1'b0;
        @(negedge clk_in);
        check("underflow_hold_zero", 32'(outstanding), 32'd0);
        check("underflow_set", 32'(err_underflow), 32'd1);
        go_to(10);
        @(negedge clk_in);
        check("underflow_sticky", 32'(err_underflow), 32'd1);
        go_to(11);
        check_sb("sb_underflow");

        // ---- Calibration loss mid write burst ----
        reset_dut();
        init_calib_complete = 1'b1;
        bus.rd_req_valid    = 1'b1;
        bus.wr_req_valid    = 1'b1;
        push_rd(1);
        push_wr(3);
        go_to(3);
        bus.rd_req_valid = 1'b0;
        go_to(8);
        init_calib_complete = 1'b0;
        go_to(9);
        @(negedge clk_in);
        check("calib_loss_stops", 32'({bus.app_en, bus.wr_req_ready}), 32'd0);
        check("calib_loss_outstanding", 32'(outstanding), 32'd1);
        go_to(10);
        bus.app_rd_data_valid = 1'b1;
        go_to(11);
        bus.app_rd_data_valid = 1'b0;
        @(negedge clk_in);
        check("return_in_wait_init", 32'(outstanding), 32'd0);
        go_to(12);
        bus.wr_req_valid    = 1'b0;
        init_calib_complete = 1'b1;
        go_to(14);
        @(negedge clk_in);
        check("recal_idle", 32'(bus.app_en), 32'd0);
        go_to(15);
        check_sb("sb_calib_loss");

        // ---- Write burst limit while reads wait ----
        reset_dut();
        init_calib_complete = 1'b1;
        bus.wr_req_valid    = 1'b1;
        push_wr(8);
        push_rd(2);
        go_to(4);
        bus.rd_req_valid = 1'b1;
        go_to(9);
        @(negedge clk_in);
        check("eighth_write", 32'({bus.app_en, bus.app_wdf_wren}), 32'd3);
        go_to(10);
        @(negedge clk_in);
        check("wr_limit_turn", 32'({bus.app_en, sel_rd}), 32'd1);
        go_to(12);
        @(negedge clk_in);
        check("reads_after_wr_limit", 32'({bus.app_en, sel_rd}), 32'd3);
        go_to(14);
        bus.rd_req_valid = 1'b0;
        bus.wr_req_valid = 1'b0;
        go_to(15);
        @(negedge clk_in);
        check("wr_limit_outstanding", 32'(outstanding), 32'd2);
        go_to(16);
        check_sb("sb_wr_limit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
